// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game encodings: game state, sequencer state, stage indices.
package game_pkg;

  localparam logic [1:0] PLAY  = 2'd0;
  localparam logic [1:0] PAUSE = 2'd1;
  localparam logic [1:0] OVER  = 2'd2;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_ISSUE = 2'd1,
    SEQ_WAIT  = 2'd2,
    SEQ_DONE  = 2'd3
  } seq_state_e;

  localparam int STG_COLLISION = 0;
  localparam int STG_DOODLE    = 1;
  localparam int STG_PLATFORMS = 2;
  localparam int STG_TABLOID   = 3;

endpackage

// File: rtl/seq_watchdog.sv
// rtl/seq_watchdog.sv - loadable down-counter; expired once a loaded count has run down to zero.
module seq_watchdog #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             run,
  output logic             expired
);

  logic [WIDTH-1:0] count_q;
  logic             armed_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q <= '0;
      armed_q <= 1'b0;
    end else if (load) begin
      count_q <= load_value;
      armed_q <= 1'b1;
    end else if (run && count_q != '0) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  // armed keeps a cleared (never loaded) counter from reading as expired
  assign expired = armed_q && (count_q == '0);

endmodule

// File: rtl/frame_update_sequencer.sv
// rtl/frame_update_sequencer.sv - runs per-frame game stages in fixed order on each frame tick.
// Optional stage watchdog enabled by defining FRAME_SEQ_WATCHDOG_EN.
module frame_update_sequencer
  import game_pkg::*;
#(
  parameter int                  STAGES          = 4,
  parameter logic [STAGES-1:0]   RUN_WHEN_HALTED = 4'b1000,
  parameter int                  TIMEOUT_CYCLES  = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_tick,
  input  logic [1:0]        game_state,
  input  logic [STAGES-1:0] stage_enable,
  input  logic [STAGES-1:0] stage_done,
  output logic [STAGES-1:0] stage_start,
  output logic              busy,
  output logic              frame_done,
  output logic [7:0]        frame_id,
  output logic              overrun,
  output logic [STAGES-1:0] timeout_flags
);

  localparam int IW = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(STAGES - 1);

  seq_state_e        state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [STAGES-1:0] mask_q;
  logic [7:0]        frame_id_q;
  logic              overrun_q;
  logic              wd_fire;

`ifdef FRAME_SEQ_WATCHDOG_EN
  localparam int WDW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic              wd_expired;
  logic [STAGES-1:0] tflags_q;

  seq_watchdog #(.WIDTH(WDW)) u_watchdog (
    .clk        (clk),
    .rst        (rst),
    .clear      (state_q == SEQ_IDLE),
    .load       (state_q == SEQ_ISSUE),
    .load_value (WDW'(TIMEOUT_CYCLES - 1)),
    .run        (state_q == SEQ_WAIT),
    .expired    (wd_expired)
  );

  // a real done in the expiry cycle wins, so the stage is not flagged
  assign wd_fire = (state_q == SEQ_WAIT) && wd_expired && !stage_done[idx_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      tflags_q <= '0;
    end else if (wd_fire) begin
      tflags_q[idx_q] <= 1'b1;
    end
  end

  assign timeout_flags = tflags_q;
`else
  assign wd_fire       = 1'b0;
  assign timeout_flags = '0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      SEQ_IDLE: begin
        if (frame_tick) begin
          state_d = SEQ_ISSUE;
          idx_d   = '0;
        end
      end
      SEQ_ISSUE: begin
        if (mask_q[idx_q]) begin
          state_d = SEQ_WAIT;
        end else if (idx_q == LAST_IDX) begin
          state_d = SEQ_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      SEQ_WAIT: begin
        if (stage_done[idx_q] || wd_fire) begin
          if (idx_q == LAST_IDX) begin
            state_d = SEQ_DONE;
          end else begin
            state_d = SEQ_ISSUE;
            idx_d   = idx_q + IW'(1);
          end
        end
      end
      SEQ_DONE: begin
        state_d = SEQ_IDLE;
      end
      default: begin
        state_d = SEQ_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SEQ_IDLE;
      idx_q      <= '0;
      mask_q     <= '0;
      frame_id_q <= 8'd0;
      overrun_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (state_q == SEQ_IDLE && frame_tick) begin
        mask_q <= (game_state != PLAY) ? (stage_enable & RUN_WHEN_HALTED) : stage_enable;
      end
      // ticks outside IDLE, including the DONE cycle, are dropped
      if (state_q != SEQ_IDLE && frame_tick) begin
        overrun_q <= 1'b1;
      end
      if (state_q == SEQ_DONE) begin
        frame_id_q <= frame_id_q + 8'd1;
      end
    end
  end

  always_comb begin
    stage_start = '0;
    if (state_q == SEQ_ISSUE && mask_q[idx_q]) begin
      stage_start[idx_q] = 1'b1;
    end
  end

  assign busy       = (state_q != SEQ_IDLE);
  assign frame_done = (state_q == SEQ_DONE);
  assign frame_id   = frame_id_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_frame_update_sequencer.sv
// tb/tb_frame_update_sequencer.sv - scoreboard bench for frame_update_sequencer.
module tb_frame_update_sequencer;
  import game_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic [1:0] game_state = PLAY;
  logic [3:0] stage_enable = 4'hF;
  logic [3:0] stage_done = 4'h0;
  logic [3:0] stage_start;
  logic       busy;
  logic       frame_done;
  logic [7:0] frame_id;
  logic       overrun;
  logic [3:0] timeout_flags;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  typedef struct {
    int         cyc;
    logic [3:0] vec;
  } ev_t;

  ev_t start_q[$];
  int  done_q[$];
  ev_t mon_ev;
  int  mon_dc;

  frame_update_sequencer #(
    .STAGES          (4),
    .RUN_WHEN_HALTED (4'b1000),
    .TIMEOUT_CYCLES  (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .frame_tick    (frame_tick),
    .game_state    (game_state),
    .stage_enable  (stage_enable),
    .stage_done    (stage_done),
    .stage_start   (stage_start),
    .busy          (busy),
    .frame_done    (frame_done),
    .frame_id      (frame_id),
    .overrun       (overrun),
    .timeout_flags (timeout_flags)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic at_cycle(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_start(input int c, input logic [3:0] v);
    ev_t e;
    e.cyc = c;
    e.vec = v;
    start_q.push_back(e);
  endtask

  task automatic pulse_tick(input int c);
    at_cycle(c);
    frame_tick = 1'b1;
    at_cycle(c + 1);
    frame_tick = 1'b0;
  endtask

  task automatic pulse_done(input int idx, input int c);
    at_cycle(c);
    stage_done = 4'b0001 << idx;
    at_cycle(c + 1);
    stage_done = 4'b0000;
  endtask

  // all stages enabled, each done two cycles after its start
  task automatic run_frame(input int t, input int fid);
    for (int i = 0; i < 4; i++) exp_start(t + 1 + 3 * i, 4'b0001 << i);
    done_q.push_back(t + 13);
    pulse_tick(t);
    for (int i = 0; i < 4; i++) pulse_done(i, t + 3 + 3 * i);
    at_cycle(t + 14);
    check("frame_id", 32'(frame_id), 32'(fid));
    check("busy_after_frame", 32'(busy), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (stage_start != 4'b0000) begin
        if (start_q.size() == 0) begin
          check("unexpected_start", 32'(stage_start), 32'd0);
        end else begin
          mon_ev = start_q.pop_front();
          check("start_vec", 32'(stage_start), 32'(mon_ev.vec));
          check("start_cycle", 32'(cyc), 32'(mon_ev.cyc));
        end
      end
      if (frame_done) begin
        if (done_q.size() == 0) begin
          check("unexpected_frame_done", 32'(frame_done), 32'd0);
        end else begin
          mon_dc = done_q.pop_front();
          check("frame_done_cycle", 32'(cyc), 32'(mon_dc));
        end
      end
    end
  end

  initial begin
    at_cycle(3);
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_start", 32'(stage_start), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_frame_id", 32'(frame_id), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_timeout", 32'(timeout_flags), 32'd0);

    // nominal: starts 11/14/17/20, frame_done 23
    run_frame(10, 1);

    // halted: only the scoreboard stage runs after three skip cycles
    game_state = OVER;
    exp_start(34, 4'b1000);
    done_q.push_back(37);
    pulse_tick(30);
    game_state = PLAY;
    at_cycle(33);
    check("halted_skip_busy", 32'(busy), 32'd1);
    pulse_done(3, 36);
    at_cycle(38);
    check("halted_frame_id", 32'(frame_id), 32'd2);

    // overrun: second tick during WAIT of stage 1 is dropped
    exp_start(41, 4'b0001);
    exp_start(44, 4'b0010);
    exp_start(48, 4'b0100);
    exp_start(51, 4'b1000);
    done_q.push_back(54);
    pulse_tick(40);
    pulse_done(0, 43);
    pulse_tick(45);
    check("overrun_set", 32'(overrun), 32'd1);
    pulse_done(1, 47);
    pulse_done(2, 50);
    pulse_done(3, 53);
    at_cycle(55);
    check("overrun_frame_id", 32'(frame_id), 32'd3);
    run_frame(60, 4);
    check("overrun_sticky", 32'(overrun), 32'd1);

    // coincident done on own start is lost; stray done[3] in stage 1 ignored
    exp_start(81, 4'b0001);
    exp_start(85, 4'b0010);
    exp_start(90, 4'b0100);
    exp_start(93, 4'b1000);
    done_q.push_back(96);
    pulse_tick(80);
    pulse_done(0, 81);
    at_cycle(83);
    check("early_done_still_busy", 32'(busy), 32'd1);
    pulse_done(0, 84);
    pulse_done(3, 87);
    check("stray_done_still_busy", 32'(busy), 32'd1);
    pulse_done(1, 89);
    pulse_done(2, 92);
    pulse_done(3, 95);
    at_cycle(97);
    check("stray_frame_id", 32'(frame_id), 32'd5);

`ifdef FRAME_SEQ_WATCHDOG_EN
    // stage 2 never answers: flagged after 16 WAIT cycles (108..123)
    exp_start(101, 4'b0001);
    exp_start(104, 4'b0010);
    exp_start(107, 4'b0100);
    exp_start(124, 4'b1000);
    done_q.push_back(127);
    pulse_tick(100);
    pulse_done(0, 103);
    pulse_done(1, 106);
    at_cycle(123);
    check("wd_not_yet", 32'(timeout_flags), 32'd0);
    at_cycle(124);
    check("wd_flag", 32'(timeout_flags), 32'b0100);
    pulse_done(3, 126);
    at_cycle(128);
    check("wd_frame_id", 32'(frame_id), 32'd6);
`endif

    // reset during WAIT of stage 1
    exp_start(141, 4'b0001);
    exp_start(144, 4'b0010);
    pulse_tick(140);
    pulse_done(0, 143);
    at_cycle(146);
    rst = 1'b1;
    at_cycle(147);
    rst = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_start", 32'(stage_start), 32'd0);
    check("mid_rst_frame_done", 32'(frame_done), 32'd0);
    check("mid_rst_frame_id", 32'(frame_id), 32'd0);
    check("mid_rst_overrun", 32'(overrun), 32'd0);
    check("mid_rst_timeout", 32'(timeout_flags), 32'd0);
    at_cycle(150);
    check("mid_rst_stays_idle", 32'(busy), 32'd0);
    run_frame(155, 1);

`ifndef FRAME_SEQ_WATCHDOG_EN
    // without the watchdog a silent stage stalls the frame indefinitely
    exp_start(181, 4'b0001);
    exp_start(184, 4'b0010);
    exp_start(187, 4'b0100);
    pulse_tick(180);
    pulse_done(0, 183);
    pulse_done(1, 186);
    at_cycle(215);
    check("stall_busy", 32'(busy), 32'd1);
    check("stall_no_timeout", 32'(timeout_flags), 32'd0);
    rst = 1'b1;
    at_cycle(216);
    rst = 1'b0;
    at_cycle(218);
    check("stall_rst_busy", 32'(busy), 32'd0);
`endif

    at_cycle(cyc + 3);
    check("start_q_drained", 32'(start_q.size()), 32'd0);
    check("done_q_drained", 32'(done_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
